// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single ZBT frame-memory port between VGA scan reads and back-buffer writes.
// Define VGA_MEM_DOUBLE_BUFFER_EN to enable double-buffer bank swapping on frame boundaries.
module vga_mem_arbiter #(
   parameter int ADDR_W      = 19,
   parameter int MEM_W       = 36,
   parameter int FRAME_WORDS = 153600
) (
   input  logic              clock,
   input  logic              reset_b,
   input  logic              frame_flag,
   input  logic              vga_flag,
   output logic [MEM_W-1:0]  vga_pixel,
   output logic              done_vga,
   input  logic              wr_req,
   input  logic [ADDR_W-2:0] wr_addr,
   input  logic [MEM_W-1:0]  wr_data,
   output logic              wr_ack,
   input  logic              swap_req,
   output logic              display_bank,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [MEM_W-1:0]  mem_wdata,
   input  logic [MEM_W-1:0]  mem_rdata
);

   localparam int SCAN_W = ADDR_W - 1;
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(FRAME_WORDS - 1);

   logic [SCAN_W-1:0] scan_cnt;
   logic [SCAN_W-1:0] rd_idx;
   logic              bank_q;
   logic              wr_bank;
   logic              vld_p1, vld_p2;
   logic [MEM_W-1:0]  pixel_hold;
   logic [ADDR_W-1:0] addr_hold;
   logic [MEM_W-1:0]  wdata_hold;

   // A frame boundary coinciding with a read restarts the scan at word 0
   assign rd_idx = frame_flag ? '0 : scan_cnt;

   always_comb begin
      mem_addr  = addr_hold;
      mem_we    = 1'b0;
      mem_wdata = wdata_hold;
      wr_ack    = 1'b0;
      if (!reset_b) begin
         mem_addr  = '0;
         mem_wdata = '0;
      end else if (vga_flag) begin
         mem_addr = {bank_q, rd_idx};
      end else if (wr_req) begin
         mem_addr  = {wr_bank, wr_addr};
         mem_we    = 1'b1;
         mem_wdata = wr_data;
         wr_ack    = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         addr_hold  <= mem_addr;
         wdata_hold <= mem_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b)
         scan_cnt <= '0;
      else if (frame_flag)
         scan_cnt <= vga_flag ? SCAN_W'(1) : '0;
      else if (vga_flag)
         scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + SCAN_W'(1);
   end

   // Stage p1/p2: in-flight read tracking, data returns in p2
   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         pixel_hold <= '0;
      end else begin
         vld_p1 <= vga_flag;
         vld_p2 <= vld_p1;
         if (vld_p2)
            pixel_hold <= mem_rdata;
      end
   end

   assign done_vga  = vld_p2;
   assign vga_pixel = vld_p2 ? mem_rdata : pixel_hold;

`ifdef VGA_MEM_DOUBLE_BUFFER_EN
   typedef enum logic {SHOWING, SWAP_PENDING} bank_state_t;

   bank_state_t state, state_nxt;
   logic        bank_nxt;

   always_ff @(posedge clock or negedge reset_b) begin
      if (!reset_b) begin
         state  <= SHOWING;
         bank_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         bank_q <= bank_nxt;
      end
   end

   // Pending swap is consumed only by a later frame boundary, never the arming one
   always_comb begin
      state_nxt = state;
      bank_nxt  = bank_q;
      case (state)
         SHOWING: begin
            if (swap_req)
               state_nxt = SWAP_PENDING;
         end
         SWAP_PENDING: begin
            if (frame_flag) begin
               bank_nxt  = ~bank_q;
               state_nxt = SHOWING;
            end
         end
      endcase
   end

   assign wr_bank = ~bank_q;
`else
   logic unused_swap;

   assign unused_swap = swap_req;
   assign bank_q      = 1'b0;
   assign wr_bank     = 1'b0;
`endif

   assign display_bank = bank_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed self-checking bench for vga_mem_arbiter (small FRAME_WORDS so the scan wrap is reachable).
module tb_vga_mem_arbiter;

   localparam int ADDR_W = 19;
   localparam int MEM_W  = 36;
   localparam int FW     = 8;
   localparam logic [MEM_W-1:0] MAGIC   = 36'h123456789;
   localparam logic [MEM_W-1:0] GARBAGE = 36'hF0F0F0F0F;
   localparam logic [MEM_W-1:0] WD1     = 36'hABCDE0123;
   localparam logic [MEM_W-1:0] WD2     = 36'h55AA33CC7;
`ifdef VGA_MEM_DOUBLE_BUFFER_EN
   localparam logic DB = 1'b1;
`else
   localparam logic DB = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset_b;
   logic              frame_flag, vga_flag, wr_req, swap_req;
   logic [ADDR_W-2:0] wr_addr;
   logic [MEM_W-1:0]  wr_data;
   logic [MEM_W-1:0]  vga_pixel, mem_wdata, mem_rdata;
   logic              done_vga, wr_ack, display_bank, mem_we;
   logic [ADDR_W-1:0] mem_addr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   vga_mem_arbiter #(.ADDR_W(ADDR_W), .MEM_W(MEM_W), .FRAME_WORDS(FW)) dut (
      .clock(clock), .reset_b(reset_b), .frame_flag(frame_flag), .vga_flag(vga_flag),
      .vga_pixel(vga_pixel), .done_vga(done_vga), .wr_req(wr_req), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ack(wr_ack), .swap_req(swap_req), .display_bank(display_bank),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // ZBT read model: data for a read address appears two cycles later, garbage otherwise
   logic [ADDR_W-1:0] a1 = '0, a2 = '0;
   logic              r1 = 1'b0, r2 = 1'b0;
   always @(posedge clock) begin
      a1 <= mem_addr;
      a2 <= a1;
      r1 <= vga_flag;
      r2 <= r1;
   end
   assign mem_rdata = r2 ? (MAGIC ^ MEM_W'(a2)) : GARBAGE;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_b = 1'b0; frame_flag = 1'b0; vga_flag = 1'b0; wr_req = 1'b0;
      swap_req = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) cyc();
      #1;
      chk("rst_pixel", vga_pixel, 0);
      chk("rst_done", done_vga, 0);
      chk("rst_ack", wr_ack, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_bank", display_bank, 0);

      // read latency and hold
      cyc(); reset_b = 1'b1;
      repeat (9) cyc();
      cyc(); vga_flag = 1'b1; #1;
      chk("rd0_addr", mem_addr, 0);
      chk("rd0_we", mem_we, 0);
      cyc(); vga_flag = 1'b0; #1;
      chk("lat_n1_done", done_vga, 0);
      cyc(); #1;
      chk("lat_done", done_vga, 1);
      chk("lat_pixel", vga_pixel, MAGIC);
      cyc(); #1;
      chk("hold_done", done_vga, 0);
      chk("hold_pixel", vga_pixel, MAGIC);

      // contention: VGA wins, write issues once VGA releases
      cyc(); wr_req = 1'b1; wr_addr = 18'd5; wr_data = WD1; vga_flag = 1'b1; #1;
      chk("cont1_ack", wr_ack, 0);
      chk("cont1_addr", mem_addr, 1);
      chk("cont1_we", mem_we, 0);
      cyc(); #1;
      chk("cont2_ack", wr_ack, 0);
      chk("cont2_addr", mem_addr, 2);
      cyc(); vga_flag = 1'b0; #1;
      chk("wr_ack", wr_ack, 1);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, {DB, 18'd5});
      chk("wr_wdata", mem_wdata, WD1);
      chk("b2b1_done", done_vga, 1);
      chk("b2b1_pixel", vga_pixel, MAGIC ^ 36'd1);
      cyc(); wr_req = 1'b0; #1;
      chk("idle_ack", wr_ack, 0);
      chk("idle_we", mem_we, 0);
      chk("idle_addr_hold", mem_addr, {DB, 18'd5});
      chk("b2b2_done", done_vga, 1);
      chk("b2b2_pixel", vga_pixel, MAGIC ^ 36'd2);

      // scan wrap at FW-1 -> 0
      for (int i = 0; i < 7; i++) begin
         cyc(); vga_flag = 1'b1; #1;
         chk("wrap_addr", mem_addr, 64'((3 + i) % FW));
      end
      cyc(); vga_flag = 1'b0; frame_flag = 1'b1;
      cyc(); frame_flag = 1'b0; vga_flag = 1'b1; #1;
      chk("ff_restart", mem_addr, 0);
      cyc(); #1;
      chk("ff_next", mem_addr, 1);
      cyc(); frame_flag = 1'b1; #1;
      chk("ff_coinc", mem_addr, 0);
      cyc(); frame_flag = 1'b0; #1;
      chk("ff_coinc_next", mem_addr, 1);
      cyc(); vga_flag = 1'b0;
      repeat (3) cyc();

      // bank swap with a repeated request while pending
      cyc(); swap_req = 1'b1; #1;
      chk("sw_bank0", display_bank, 0);
      cyc(); swap_req = 1'b0;
      repeat (3) cyc();
      cyc(); swap_req = 1'b1;
      cyc(); swap_req = 1'b0;
      repeat (2) cyc();
      cyc(); frame_flag = 1'b1; wr_req = 1'b1; wr_addr = 18'd9; wr_data = WD2; #1;
      chk("sw_ff_ack", wr_ack, 1);
      chk("sw_ff_addr", mem_addr, {DB, 18'd9});
      chk("sw_ff_bank", display_bank, 0);
      cyc(); frame_flag = 1'b0; #1;
      chk("sw_post_addr", mem_addr, {1'b0, 18'd9});
      chk("sw_post_bank", display_bank, DB);
      cyc(); wr_req = 1'b0; frame_flag = 1'b1;
      cyc(); frame_flag = 1'b0; #1;
      chk("single_toggle", display_bank, DB);
      cyc(); vga_flag = 1'b1; #1;
      chk("rd_bank", mem_addr[ADDR_W-1], DB);
      cyc(); vga_flag = 1'b0; swap_req = 1'b1; frame_flag = 1'b1;
      cyc(); swap_req = 1'b0; frame_flag = 1'b0; #1;
      chk("coinc_no_toggle", display_bank, DB);
      cyc(); frame_flag = 1'b1;
      cyc(); frame_flag = 1'b0; #1;
      chk("coinc_toggle", display_bank, 0);

      // asynchronous reset with a read in flight
      repeat (3) cyc();
      cyc(); vga_flag = 1'b1;
      cyc(); #1;
      cyc(); vga_flag = 1'b0; reset_b = 1'b0; #1;
      chk("ar_done", done_vga, 0);
      chk("ar_pixel", vga_pixel, 0);
      chk("ar_addr", mem_addr, 0);
      chk("ar_we", mem_we, 0);
      chk("ar_ack", wr_ack, 0);
      chk("ar_wdata", mem_wdata, 0);
      chk("ar_bank", display_bank, 0);
      repeat (2) cyc();
      cyc(); reset_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         chk("ar_no_done", done_vga, 0);
      end
      cyc(); vga_flag = 1'b1; #1;
      chk("ar_scan0", mem_addr, 0);
      cyc(); vga_flag = 1'b0;
      repeat (3) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Owns the single ZBT frame-memory port and arbitrates it between the VGA read path and the frame-writer path. It sits directly upstream of the VGA output stage: it answers `vga_flag` word requests with fixed-latency `vga_pixel` data. It also lets a producer (camera/processing) write the back buffer in any cycle the VGA path leaves free. It maintains the VGA scan address and performs double-buffer bank swaps on frame boundaries.

## Interface
Parameters:
- `ADDR_W`, 19: ZBT word-address width; bit `ADDR_W-1` is the bank bit.
- `MEM_W`, 36: ZBT word width; one word = two packed pixels.
- `FRAME_WORDS`, 153600: words per frame (640×480/2).

Ports:
- `clock` in 1: system clock; the only clock.
- `reset_b` in 1: asynchronous, active-low reset.
- `frame_flag` in 1: one-cycle frame-boundary pulse.
- `vga_flag` in 1: VGA read request, one word.
- `vga_pixel` out MEM_W: returned VGA word.
- `done_vga` out 1: one-cycle pulse, `vga_pixel` valid.
- `wr_req` in 1: writer requests a write.
- `wr_addr` in ADDR_W-1: writer word address within the back bank.
- `wr_data` in MEM_W: writer data.
- `wr_ack` out 1: write issued this cycle; writer may advance.
- `swap_req` in 1: pulse; back buffer complete, swap at next `frame_flag`.
- `display_bank` out 1: bank currently scanned out.
- `mem_addr` out ADDR_W: ZBT address.
- `mem_we` out 1: ZBT write enable.
- `mem_wdata` out MEM_W: ZBT write data.
- `mem_rdata` in MEM_W: ZBT read data, valid 2 cycles after its address cycle.

## Operation
- **Scan counter** `scan_cnt` (ADDR_W-1 bits):
  - Increments on every accepted `vga_flag`.
  - Wraps from `FRAME_WORDS-1` to 0.
  - Forced to 0 by `frame_flag`.
  - If `frame_flag` and `vga_flag` coincide, the read uses address `{display_bank,0}` and `scan_cnt` becomes 1.
- **Arbitration**, combinational, decided per cycle:
  - `vga_flag`=1: `mem_addr={display_bank,scan_cnt}`, `mem_we`=0, `wr_ack`=0. VGA always wins.
  - else `wr_req`=1: `mem_addr={~display_bank,wr_addr}`, `mem_we`=1, `mem_wdata=wr_data`, `wr_ack`=1.
  - else: `mem_we`=0, `mem_addr` holds its last value.
- **Read return:**
  - A 2-stage shift register `rd_pipe` tracks in-flight VGA reads.
  - When a tracked read reaches stage 2, `mem_rdata` is captured into the `vga_pixel` hold register and `done_vga` pulses.
  - `vga_pixel` is driven from `mem_rdata` in the return cycle and holds that value until the next return.
- **Bank state machine** `{SHOWING, SWAP_PENDING}`:
  - SHOWING: `swap_req` → SWAP_PENDING.
  - SWAP_PENDING: `frame_flag` → toggle `display_bank`, go to SHOWING.
  - `swap_req` while already pending is ignored.
  - `swap_req` coincident with `frame_flag` in SHOWING: go to SWAP_PENDING; no toggle this frame.
- **`wr_ack` across a swap:** in the `frame_flag` cycle that toggles the bank, a granted write still targets the old back bank (uses the pre-toggle `display_bank`).

## Timing
- **Reset values:** `vga_pixel`=0, `done_vga`=0, `wr_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `display_bank`=0, `scan_cnt`=0, state SHOWING, `rd_pipe` cleared.
- **Read latency:** `vga_flag` in cycle N → `done_vga` and valid `vga_pixel` in cycle N+2. This is fixed and never stalled.
- **Request rate:** back-to-back `vga_flag` every cycle is legal; each gets its own return pulse two cycles later.
- **Write handshake:** the `wr_ack` cycle is the issue cycle. The writer holds `wr_req`/`wr_addr`/`wr_data` until `wr_ack`; there is no write-data latency.
- **Reset mid-operation:** asserting `reset_b` low clears everything immediately. In-flight reads produce no `done_vga` after reset release.
- **Mem outputs:** `mem_addr`/`mem_we`/`mem_wdata` are combinational from requests. The ZBT controller registers them.

## Configuration
- `VGA_MEM_DOUBLE_BUFFER_EN` defined:
  - Bank logic as above.
  - Reads use `display_bank`; writes go to the opposite bank.
- `VGA_MEM_DOUBLE_BUFFER_EN` undefined:
  - `display_bank` is tied to 0 and `swap_req` is ignored.
  - Both reads and writes use bank 0, so writes go to `{1'b0,wr_addr}`.
  - The state machine is removed.

## Test plan
- **Reset and read latency:** release reset; pulse `vga_flag` at cycle 10 with `mem_rdata` model returning 36'h123456789 → `mem_addr`=0 at cycle 10; `done_vga` only at cycle 12; `vga_pixel`=36'h123456789, held until the next return.
- **Arbitration under contention:** hold `wr_req`=1 (`wr_addr`=5) with `vga_flag` high in cycles 3,4 → `wr_ack` low in cycles 3,4; `wr_ack`=1 in cycle 5 with `mem_addr`={1,5}, `mem_we`=1.
- **Scan wrap:** issue `FRAME_WORDS`+1 requests with no `frame_flag` → addresses 0…153599, then 0. `frame_flag` mid-scan → next read at address 0.
- **Bank swap:** `swap_req` at cycle 20, `frame_flag` at 100 → `display_bank` 0→1 after 100; a write granted at 100 uses bank 1, a write granted at 101 uses bank 0. A second `swap_req` while pending produces a single toggle.
- **Async reset:** drop `reset_b` one cycle after `vga_flag` → all outputs 0 immediately; no `done_vga` after release.
- **Configuration:** with `VGA_MEM_DOUBLE_BUFFER_EN` undefined, `swap_req`+`frame_flag` → `display_bank` stays 0; write `mem_addr` MSB=0.
